// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding, PHASEDIR constants and sizing helper for the PLL controllers
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    STEP_SETUP,
    STEP_LOW,
    STEP_SETTLE
  } pll_ctrl_state_t;
  localparam logic PHASEDIR_ADVANCE = 1'b0;
  localparam logic PHASEDIR_DELAY = 1'b1;
  localparam int LOSS_COUNT_W = 8;
  function automatic int max3(input int a, input int b, input int c);
    return ((a > b) ? a : b) > c ? ((a > b) ? a : b) : c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit (clk in, d async in, q synchronised out)
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end
  assign q = sync_q;
endmodule

// File: rtl/pll_reset_phase_ctrl.sv
// pll_reset_phase_ctrl: ECP5 EHXPLLL lock qualifier, staggered reset release and dynamic phase stepper
//   clock/reset          reference clock, sync active-high reset
//   pll_locked           async PLL LOCK, synchronised internally
//   rst_out/all_ready    per-output resets (1 = held), all released and lock intact
//   phase_req/sel/dir    level request for one phase step; phase_ack/phase_err one-cycle replies
//   pll_phase*           PHASESEL/PHASEDIR/PHASESTEP pins to the PLL
//   lock_loss_count      saturating count of lock losses after first release
module pll_reset_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP = 16,
  parameter int STEP_PULSE = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  output logic [NUM_OUT-1:0]      rst_out,
  output logic                    all_ready,
  input  logic                    phase_req,
  input  logic [1:0]              phase_sel,
  input  logic                    phase_dir,
  output logic                    phase_ack,
  output logic                    phase_err,
  output logic [1:0]              pll_phasesel,
  output logic                    pll_phasedir,
  output logic                    pll_phasestep,
  output logic [LOSS_COUNT_W-1:0] lock_loss_count
);
  localparam int CW = $clog2(max3(LOCK_STABLE_CYCLES, RELEASE_GAP * NUM_OUT, STEP_PULSE)) + 1;
  pll_ctrl_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic [LOSS_COUNT_W-1:0] loss_q, loss_d;
  logic [1:0] sel_q, sel_d, psel_q, psel_d;
  logic ready_q, ready_d, ack_q, ack_d, err_q, err_d;
  logic dir_q, dir_d, pdir_q, pdir_d, pstep_q, pstep_d;
  logic lk_s, lost, rel;
  sync_2ff u_lock_sync (.clk(clock), .d(pll_locked), .q(lk_s));
  assign lost = !lk_s && !(state_q inside {WAIT_LOCK, STABLE});
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    rst_d = rst_q;
    ready_d = ready_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    sel_d = sel_q;
    dir_d = dir_q;
    psel_d = psel_q;
    pdir_d = pdir_q;
    pstep_d = pstep_q;
    loss_d = loss_q;
    rel = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        state_d = lk_s ? STABLE : WAIT_LOCK;
      end
      // The WAIT_LOCK cycle that saw lock is the first of the stable window.
      STABLE: begin
        if (!lk_s) state_d = WAIT_LOCK;
        else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 2)) begin
          cnt_d = '0;
          state_d = RELEASE;
          rel = 1'b1;
        end
      end
      RELEASE: rel = 1'b1;
      RUN: begin
        if (phase_req && !ack_q) begin
          sel_d = phase_sel;
          dir_d = phase_dir;
          if (int'(phase_sel) >= NUM_OUT) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else state_d = STEP_SETUP;
        end
      end
      STEP_SETUP: begin
        psel_d = sel_q;
        pdir_d = dir_q;
        pstep_d = 1'b0;
        cnt_d = '0;
        state_d = STEP_LOW;
      end
      STEP_LOW: begin
        if (cnt_q == CW'(STEP_PULSE - 1)) begin
          pstep_d = 1'b1;
          cnt_d = '0;
          state_d = STEP_SETTLE;
        end
      end
      STEP_SETTLE: begin
        if (cnt_q == CW'(STEP_PULSE - 1)) begin
          ack_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Release schedule keyed on the next counter value so output 0 drops on RELEASE entry.
    for (int i = 0; i < NUM_OUT; i++)
      if (rel && cnt_d == CW'(i * RELEASE_GAP)) rst_d[i] = 1'b0;
    if (rel && cnt_d == CW'((NUM_OUT - 1) * RELEASE_GAP)) begin
      ready_d = 1'b1;
      state_d = RUN;
    end
    if (lost) begin
      rst_d = '1;
      ready_d = 1'b0;
      pstep_d = 1'b1;
      ack_d = 1'b0;
      err_d = 1'b0;
      state_d = WAIT_LOCK;
      loss_d = &loss_q ? loss_q : loss_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      rst_q <= '1;
      ready_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      sel_q <= '0;
      dir_q <= PHASEDIR_DELAY;
      psel_q <= '0;
      pdir_q <= PHASEDIR_DELAY;
      pstep_q <= 1'b1;
      loss_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rst_q <= rst_d;
      ready_q <= ready_d;
      ack_q <= ack_d;
      err_q <= err_d;
      sel_q <= sel_d;
      dir_q <= dir_d;
      psel_q <= psel_d;
      pdir_q <= pdir_d;
      pstep_q <= pstep_d;
      loss_q <= loss_d;
    end
  end
  assign rst_out = rst_q;
  assign all_ready = ready_q;
  assign phase_ack = ack_q;
  assign phase_err = err_q;
  assign pll_phasesel = psel_q;
  assign pll_phasedir = pdir_q;
  assign pll_phasestep = pstep_q;
  assign lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_reset_phase_ctrl.sv
// tb_pll_reset_phase_ctrl: directed checks of lock qualification, reset release, phase stepping and lock loss
module tb_pll_reset_phase_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic a_lock = 1'b0, a_req = 1'b0, a_dir = 1'b0;
  logic [1:0] a_sel = '0;
  logic [3:0] a_rst;
  logic a_ready, a_ack, a_err, a_pdir, a_pstep;
  logic [1:0] a_psel;
  logic [7:0] a_loss;
  logic b_lock = 1'b0, b_req = 1'b0, b_dir = 1'b0;
  logic [1:0] b_sel = '0;
  logic [2:0] b_rst;
  logic b_ready, b_ack, b_err, b_pdir, b_pstep;
  logic [1:0] b_psel;
  logic [7:0] b_loss;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  pll_reset_phase_ctrl u_a (
    .clock(clk), .reset(reset), .pll_locked(a_lock), .rst_out(a_rst), .all_ready(a_ready),
    .phase_req(a_req), .phase_sel(a_sel), .phase_dir(a_dir), .phase_ack(a_ack), .phase_err(a_err),
    .pll_phasesel(a_psel), .pll_phasedir(a_pdir), .pll_phasestep(a_pstep), .lock_loss_count(a_loss)
  );
  pll_reset_phase_ctrl #(.NUM_OUT(3), .LOCK_STABLE_CYCLES(4), .RELEASE_GAP(2), .STEP_PULSE(2)) u_b (
    .clock(clk), .reset(reset), .pll_locked(b_lock), .rst_out(b_rst), .all_ready(b_ready),
    .phase_req(b_req), .phase_sel(b_sel), .phase_dir(b_dir), .phase_ack(b_ack), .phase_err(b_err),
    .pll_phasesel(b_psel), .pll_phasedir(b_pdir), .pll_phasestep(b_pstep), .lock_loss_count(b_loss)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit hit(input int w);
    return w < 4 ? !a_rst[w[1:0]] : w == 4 ? b_ready : w == 5 ? !b_rst[0] : b_rst == 3'b111;
  endfunction
  task automatic wait_for(input int w, input int bound, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!hit(w) && k < bound);
  endtask
  task automatic run_step(input bit b, input logic [1:0] sel, input logic dir,
                          output logic [15:0] stp, output logic [15:0] ack, output logic [15:0] err,
                          output logic [2:0] pins1, output logic [2:0] pins2);
    @(negedge clk);
    if (b) {b_req, b_sel, b_dir} = {1'b1, sel, dir};
    else {a_req, a_sel, a_dir} = {1'b1, sel, dir};
    stp = '0;
    ack = '0;
    err = '0;
    pins1 = '0;
    pins2 = '0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      stp[k] = b ? b_pstep : a_pstep;
      ack[k] = b ? b_ack : a_ack;
      err[k] = b ? b_err : a_err;
      if (k == 1) pins1 = b ? {b_psel, b_pdir} : {a_psel, a_pdir};
      if (k == 2) pins2 = b ? {b_psel, b_pdir} : {a_psel, a_pdir};
      if (ack[k]) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
  endtask
  initial begin
    int k, tmo;
    logic [15:0] stp, ack, err;
    logic [2:0] p1, p2;
    logic seen;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_out", a_rst, 4'hf);
    check("all_ready", a_ready, 0);
    check("ack", a_ack, 0);
    check("err", a_err, 0);
    check("phasesel", a_psel, 0);
    check("phasedir", a_pdir, 1);
    check("phasestep", a_pstep, 1);
    check("loss", a_loss, 0);
    check("b_rst_out", b_rst, 3'h7);
    reset = 1'b0;
    @(negedge clk);
    a_lock = 1'b1;
    wait_for(0, 3000, k);
    check("rel0_lat", k, 1026);
    check("rel0_rst", a_rst, 4'he);
    wait_for(1, 100, k);
    check("rel1_gap", k, 16);
    wait_for(2, 100, k);
    check("rel2_gap", k, 16);
    check("rel2_not_ready", a_ready, 0);
    wait_for(3, 100, k);
    check("rel3_gap", k, 16);
    check("rel3_ready", a_ready, 1);
    check("rel3_rst", a_rst, 4'h0);
    run_step(0, 2'd2, 1'b1, stp, ack, err, p1, p2);
    check("s1_step", stp, 16'hffc2);
    check("s1_ack", ack, 16'h0400);
    check("s1_err", err, 0);
    check("s1_pins_t1", p1, 3'b001);
    check("s1_pins_t2", p2, 3'b101);
    run_step(0, 2'd1, 1'b0, stp, ack, err, p1, p2);
    check("s2_step", stp, 16'hffc2);
    check("s2_ack", ack, 16'h0400);
    check("s2_pins_t1", p1, 3'b101);
    check("s2_pins_t2", p2, 3'b010);
    @(negedge clk);
    {a_req, a_sel, a_dir} = {1'b1, 2'd3, 1'b1};
    repeat (2) @(negedge clk);
    check("ll_low", a_pstep, 0);
    a_lock = 1'b0;
    seen = 1'b0;
    for (int i = 3; i < 15; i++) begin
      @(negedge clk);
      seen |= a_ack;
      if (i == 4) check("ll_pre_step", {a_pstep, a_rst}, 5'h00);
      if (i == 5) begin
        check("ll_step", a_pstep, 1);
        check("ll_rst", a_rst, 4'hf);
        check("ll_ready", a_ready, 0);
        check("ll_count", a_loss, 1);
      end
    end
    check("ll_no_ack", seen, 0);
    a_req = 1'b0;
    @(negedge clk);
    a_lock = 1'b1;
    repeat (502) @(negedge clk);
    a_lock = 1'b0;
    @(negedge clk);
    a_lock = 1'b1;
    wait_for(0, 3000, k);
    check("glitch_lat", k, 1026);
    check("glitch_rst", a_rst, 4'he);
    check("glitch_count", a_loss, 1);
    @(negedge clk);
    b_lock = 1'b1;
    wait_for(4, 100, k);
    check("b_ready_lat", k, 10);
    check("b_rst", b_rst, 3'h0);
    run_step(1, 2'd3, 1'b0, stp, ack, err, p1, p2);
    check("b_bad_ack", ack, 16'h0002);
    check("b_bad_err", err, 16'h0002);
    check("b_bad_step", stp, 16'hfffe);
    check("b_bad_pins", {p1, p2}, 6'b001001);
    run_step(1, 2'd2, 1'b1, stp, ack, err, p1, p2);
    check("b_top_step", stp, 16'hfff2);
    check("b_top_ack", ack, 16'h0040);
    check("b_top_err", err, 0);
    check("b_top_pins", p2, 3'b101);
    tmo = 0;
    for (int i = 0; i < 260; i++) begin
      b_lock = 1'b1;
      wait_for(5, 50, k);
      tmo += int'(!hit(5));
      b_lock = 1'b0;
      wait_for(6, 20, k);
      tmo += int'(!hit(6));
    end
    check("sat_timeouts", tmo, 0);
    check("sat_count", b_loss, 255);
    b_lock = 1'b1;
    wait_for(4, 100, k);
    check("b_relock_ready", b_ready, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_b_count", b_loss, 0);
    check("rst_b_rst", b_rst, 3'h7);
    check("rst_b_ready", b_ready, 0);
    check("rst_a_count", a_loss, 0);
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
